// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multdiv results queue in a FIFO.
// Optional WAW squash of queued results on pipeline writes: define WB_WAW_SQUASH_EN.
module regfile_write_arbiter #(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   ctrl_reset,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_reg,
  input  logic [31:0]            wb_data,
  input  logic                   md_valid,
  output logic                   md_ready,
  input  logic [4:0]             md_reg,
  input  logic [31:0]            md_data,
  output logic                   ctrl_writeEnable,
  output logic [4:0]             ctrl_writeReg,
  output logic [31:0]            data_writeReg,
  output logic                   pending,
  output logic [$clog2(DEPTH):0] pending_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [DEPTH-1:0]       entValid;
  logic [DEPTH-1:0][4:0]  entReg;
  logic [DEPTH-1:0][31:0] entData;
  logic [AW-1:0]          headPtr, tailPtr;
  logic [AW:0]            count;

  logic wbGrant, headExists, headLive, fifoGrant, pop, accept, push, enqValid;

  assign wbGrant    = wb_valid && (wb_reg != 5'd0);
  assign headExists = (count != '0);
  assign headLive   = headExists && entValid[headPtr];
  // Reset gates the FIFO side so nothing stale reaches the regfile in the reset cycle.
  assign fifoGrant  = !wbGrant && headLive && !ctrl_reset;
  // A squashed head retires without the port, so it may pop under a pipeline write.
  assign pop        = headExists && (!entValid[headPtr] || !wbGrant);
  assign md_ready   = (count < FULL);
  assign accept     = md_valid && md_ready;
  assign push       = accept && (md_reg != 5'd0);

`ifdef WB_WAW_SQUASH_EN
  assign enqValid = !(wbGrant && (md_reg == wb_reg));
`else
  assign enqValid = 1'b1;
`endif

  always_comb begin
    ctrl_writeEnable = 1'b0;
    ctrl_writeReg    = 5'd0;
    data_writeReg    = 32'd0;
    if (wbGrant) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = wb_reg;
      data_writeReg    = wb_data;
    end else if (fifoGrant) begin
      ctrl_writeEnable = 1'b1;
      ctrl_writeReg    = entReg[headPtr];
      data_writeReg    = entData[headPtr];
    end
  end

  assign pending       = headExists;
  assign pending_count = count;

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      count    <= '0;
      headPtr  <= '0;
      tailPtr  <= '0;
      entValid <= '0;
    end else begin
`ifdef WB_WAW_SQUASH_EN
      if (wbGrant)
        for (int i = 0; i < DEPTH; i++)
          if (entReg[i] == wb_reg) entValid[i] <= 1'b0;
`endif
      if (push) begin
        entValid[tailPtr] <= enqValid;
        tailPtr           <= tailPtr + 1'b1;
      end
      if (pop) headPtr <= headPtr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Payload needs no reset; the valid bits and count qualify it.
  always_ff @(posedge clock) begin
    if (push) begin
      entReg[tailPtr]  <= md_reg;
      entData[tailPtr] <= md_data;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed vector table plus a queue-model random run for regfile_write_arbiter (DEPTH=4).
module tb_regfile_write_arbiter;
`ifdef WB_WAW_SQUASH_EN
  localparam bit SQ = 1'b1;
`else
  localparam bit SQ = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        ctrl_reset, wb_valid, md_valid, md_ready;
  logic [4:0]  wb_reg, md_reg, ctrl_writeReg;
  logic [31:0] wb_data, md_data, data_writeReg;
  logic        ctrl_writeEnable, pending;
  logic [2:0]  pending_count;

  regfile_write_arbiter #(.DEPTH(4)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_reg(md_reg), .md_data(md_data),
    .ctrl_writeEnable(ctrl_writeEnable), .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg), .pending(pending), .pending_count(pending_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic rst, wbV; logic [4:0] wbR; logic [31:0] wbD;
    logic mdV; logic [4:0] mdR; logic [31:0] mdD;
    logic eWe; logic [4:0] eReg; logic [31:0] eData; logic eRdy; logic [2:0] eCnt;
  } vec_t;

  typedef struct { logic v; logic [4:0] r; logic [31:0] d; } ent_t;

  vec_t tbl[$];
  ent_t q[$];
  int   checks = 0;
  int   failures = 0;

  function automatic vec_t mk(logic rst, logic wbV, logic [4:0] wbR, logic [31:0] wbD,
                              logic mdV, logic [4:0] mdR, logic [31:0] mdD,
                              logic eWe, logic [4:0] eReg, logic [31:0] eData,
                              logic eRdy, logic [2:0] eCnt);
    vec_t v;
    v.rst = rst; v.wbV = wbV; v.wbR = wbR; v.wbD = wbD;
    v.mdV = mdV; v.mdR = mdR; v.mdD = mdD;
    v.eWe = eWe; v.eReg = eReg; v.eData = eData; v.eRdy = eRdy; v.eCnt = eCnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic wbV, input logic [4:0] wbR, input logic [31:0] wbD,
                       input logic mdV, input logic [4:0] mdR, input logic [31:0] mdD);
    ctrl_reset = rst; wb_valid = wbV; wb_reg = wbR; wb_data = wbD;
    md_valid = mdV; md_reg = mdR; md_data = mdD;
  endtask

  task automatic chkOut(input string tag, input logic eWe, input logic [4:0] eReg,
                        input logic [31:0] eData, input logic eRdy, input logic [2:0] eCnt);
    chk({tag, ".we"},    32'(ctrl_writeEnable), 32'(eWe));
    chk({tag, ".reg"},   32'(ctrl_writeReg),    32'(eReg));
    chk({tag, ".data"},  data_writeReg,         eData);
    chk({tag, ".ready"}, 32'(md_ready),         32'(eRdy));
    chk({tag, ".count"}, 32'(pending_count),    32'(eCnt));
    chk({tag, ".pend"},  32'(pending),          32'(eCnt != 3'd0));
  endtask

  initial begin
    // Reset state / basic pass-through
    tbl.push_back(mk(0,0,0,0,          0,0,0,            0,0,0,1,0));
    tbl.push_back(mk(0,1,4,32'h44,     0,0,0,            1,4,32'h44,1,0));
    // Single result latency
    tbl.push_back(mk(0,0,0,0,          1,5,32'hDEADBEEF, 0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            1,5,32'hDEADBEEF,1,1));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            0,0,0,1,0));
    // Fill behind a busy port, then drain in order
    tbl.push_back(mk(0,1,3,32'h33,     1,10,32'hA0,      1,3,32'h33,1,0));
    tbl.push_back(mk(0,1,3,32'h33,     1,11,32'hA1,      1,3,32'h33,1,1));
    tbl.push_back(mk(0,1,3,32'h33,     1,12,32'hA2,      1,3,32'h33,1,2));
    tbl.push_back(mk(0,1,3,32'h33,     1,13,32'hA3,      1,3,32'h33,1,3));
    tbl.push_back(mk(0,1,3,32'h33,     1,14,32'hA4,      1,3,32'h33,0,4));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            1,10,32'hA0,0,4));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            1,11,32'hA1,1,3));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            1,12,32'hA2,1,2));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            1,13,32'hA3,1,1));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            0,0,0,1,0));
    // Pipeline r0 write leaves port to FIFO; md_reg=0 discarded
    tbl.push_back(mk(0,0,0,0,          1,7,32'h77,       0,0,0,1,0));
    tbl.push_back(mk(0,1,0,32'h99,     1,0,32'h55,       1,7,32'h77,1,1));
    tbl.push_back(mk(0,1,2,32'h22,     1,0,32'h56,       1,2,32'h22,1,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            0,0,0,1,0));
    // Reset while full with a handshake offered
    tbl.push_back(mk(0,1,1,32'h1,      1,20,32'hB0,      1,1,32'h1,1,0));
    tbl.push_back(mk(0,1,1,32'h1,      1,21,32'hB1,      1,1,32'h1,1,1));
    tbl.push_back(mk(0,1,1,32'h1,      1,22,32'hB2,      1,1,32'h1,1,2));
    tbl.push_back(mk(0,1,1,32'h1,      1,23,32'hB3,      1,1,32'h1,1,3));
    tbl.push_back(mk(1,0,0,0,          1,24,32'hC0,      0,0,0,0,4));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            0,0,0,1,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            0,0,0,1,0));
    // WAW: queued reg 9 then pipeline write to reg 9
    tbl.push_back(mk(0,1,1,32'h1,      1,9,32'h11,       1,1,32'h1,1,0));
    tbl.push_back(mk(0,1,9,32'h22,     0,0,0,            1,9,32'h22,1,1));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            !SQ,SQ?5'd0:5'd9,SQ?32'h0:32'h11,1,1));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            0,0,0,1,0));
    // WAW: acceptance in the same cycle as a pipeline write to the same reg
    tbl.push_back(mk(0,1,6,32'h66,     1,6,32'h60,       1,6,32'h66,1,0));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            !SQ,SQ?5'd0:5'd6,SQ?32'h0:32'h60,1,1));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            0,0,0,1,0));
    // WAW: squashed head retires even while the pipeline holds the port
    tbl.push_back(mk(0,1,8,32'h88,     1,8,32'h80,       1,8,32'h88,1,0));
    tbl.push_back(mk(0,1,2,32'h2,      0,0,0,            1,2,32'h2,1,1));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            !SQ,SQ?5'd0:5'd8,SQ?32'h0:32'h80,1,SQ?3'd0:3'd1));
    tbl.push_back(mk(0,0,0,0,          0,0,0,            0,0,0,1,0));

    drive(1,0,0,0,0,0,0);
    @(posedge clock);
    foreach (tbl[i]) begin
      @(negedge clock);
      drive(tbl[i].rst, tbl[i].wbV, tbl[i].wbR, tbl[i].wbD, tbl[i].mdV, tbl[i].mdR, tbl[i].mdD);
      #1;
      chkOut($sformatf("vec%0d", i), tbl[i].eWe, tbl[i].eReg, tbl[i].eData, tbl[i].eRdy, tbl[i].eCnt);
    end

    // Random traffic against a queue model
    @(negedge clock);
    drive(1,0,0,0,0,0,0);
    @(posedge clock);
    q.delete();
    for (int c = 0; c < 3000; c++) begin
      logic wbV, mdV, wbG, hasHead, rdy, doPop, eWe;
      logic [4:0] wbR, mdR, eReg;
      logic [31:0] eData;
      ent_t e;
      @(negedge clock);
      wbV = ($urandom_range(0, 99) < 45);
      mdV = ($urandom_range(0, 99) < 55);
      wbR = 5'($urandom_range(0, 7));
      mdR = 5'($urandom_range(0, 7));
      drive(0, wbV, wbR, $urandom, mdV, mdR, $urandom);
      #1;
      wbG = wbV && wbR != 0;
      hasHead = q.size() > 0;
      rdy = q.size() < 4;
      eWe = 0; eReg = 0; eData = 0;
      if (wbG) begin eWe = 1; eReg = wbR; eData = wb_data; end
      else if (hasHead && q[0].v) begin eWe = 1; eReg = q[0].r; eData = q[0].d; end
      chkOut($sformatf("rnd%0d", c), eWe, eReg, eData, rdy, 3'(q.size()));
      doPop = hasHead && (!q[0].v || !wbG);
      if (SQ && wbG)
        foreach (q[k]) if (q[k].r == wbR) q[k].v = 1'b0;
      if (doPop) void'(q.pop_front());
      if (mdV && rdy && mdR != 0) begin
        e.v = !(SQ && wbG && mdR == wbR); e.r = mdR; e.d = md_data;
        q.push_back(e);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
